// File: rtl/motion_pkg.sv
// Shared motion definitions: FSM state encoding, turn-command bit layout,
// wheel direction constants and the wheel-command helper used while turning.
package motion_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TURN   = 2'd1,
        ST_SETTLE = 2'd2,
        ST_DRIVE  = 2'd3
    } state_e;

    localparam int CMD_W         = 10;
    localparam int CMD_CW        = 9;
    localparam int CMD_SPIN      = 8;
    localparam int CMD_ANGLE_MSB = 7;
    localparam int CMD_ANGLE_LSB = 0;
    localparam int TIMER_W       = 24;

    localparam logic DIR_FWD = 1'b1;
    localparam logic DIR_REV = 1'b0;

    localparam logic [7:0] DEFAULT_TURN_SPEED  = 8'd64;
    localparam logic [7:0] DEFAULT_DRIVE_SPEED = 8'd128;

    typedef struct packed {
        logic [7:0] left_speed;
        logic [7:0] right_speed;
        logic       left_dir;
        logic       right_dir;
    } wheel_cmd_t;

    localparam wheel_cmd_t WHEELS_STOP = '{
        left_speed:  8'd0,
        right_speed: 8'd0,
        left_dir:    DIR_FWD,
        right_dir:   DIR_FWD
    };

    // A pivot keeps the inner wheel stopped (facing forward); a spin drives both in opposition.
    function automatic wheel_cmd_t turn_wheels(input logic cw, input logic spin,
                                               input logic [7:0] speed);
        wheel_cmd_t w;
        w = WHEELS_STOP;
        if (spin) begin
            w.left_speed  = speed;
            w.right_speed = speed;
            w.left_dir    = cw ? DIR_FWD : DIR_REV;
            w.right_dir   = cw ? DIR_REV : DIR_FWD;
        end else if (cw) begin
            w.left_speed  = speed;
        end else begin
            w.right_speed = speed;
        end
        return w;
    endfunction

endpackage

// File: rtl/turn_timer.sv
// Loadable down-counter timing both the TURN and SETTLE phases.
// A load of N gives N+1 cycles before expired_o is seen while counting.
module turn_timer
    import motion_pkg::*;
#(
    parameter int W = TIMER_W
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] value_i,
    input  logic         enable_i,
    output logic         expired_o
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= value_i;
        end else if (enable_i && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign expired_o = (count_q == '0);

endmodule

// File: rtl/random_move_executor.sv
// Turns a random turn command into timed wheel commands: turn, settle, then drive
// straight until random mode releases the wheels or a new command arrives.
module random_move_executor
    import motion_pkg::*;
#(
    parameter int         TICKS_PER_DEG = 16,
    parameter int         SETTLE_CYCLES = 4,
    parameter logic [7:0] TURN_SPEED    = DEFAULT_TURN_SPEED,
    parameter logic [7:0] DRIVE_SPEED   = DEFAULT_DRIVE_SPEED
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             random_enable,
    input  logic             cmd_load,
    input  logic [CMD_W-1:0] cmd,
    output logic [7:0]       left_speed,
    output logic [7:0]       right_speed,
    output logic             left_dir,
    output logic             right_dir,
    output logic             busy,
    output logic             turn_done
);

    localparam longint MAX_TURN_TICKS = 64'd255 * longint'(TICKS_PER_DEG);

    if (MAX_TURN_TICKS > 64'd16777215) begin : g_turn_too_long
        $error("random_move_executor: 255*TICKS_PER_DEG exceeds the 24-bit turn timer");
    end
    if (TICKS_PER_DEG < 1 || SETTLE_CYCLES < 1) begin : g_bad_durations
        $error("random_move_executor: TICKS_PER_DEG and SETTLE_CYCLES must be at least 1");
    end

    localparam logic [TIMER_W-1:0] TICKS       = TIMER_W'(TICKS_PER_DEG);
    localparam logic [TIMER_W-1:0] SETTLE_LOAD = TIMER_W'(SETTLE_CYCLES - 1);

    state_e             state_q, state_d;
    logic [CMD_W-1:0]   cmd_q, cmd_d;
    wheel_cmd_t         wheels_q, wheels_d;
    logic               busy_q, busy_d;
    logic               turn_done_q, turn_done_d;

    logic               timer_load;
    logic               timer_enable;
    logic               timer_expired;
    logic [TIMER_W-1:0] timer_value;
    logic [TIMER_W-1:0] turn_load;
    logic [7:0]         new_angle;

    assign new_angle = cmd[CMD_ANGLE_MSB:CMD_ANGLE_LSB];
    assign turn_load = TIMER_W'(new_angle) * TICKS - 1'b1;

    turn_timer #(.W(TIMER_W)) u_turn_timer (
        .clk_i     (clk),
        .rst_ni    (rst),
        .load_i    (timer_load),
        .value_i   (timer_value),
        .enable_i  (timer_enable),
        .expired_o (timer_expired)
    );

    // Priority: loss of random mode, then a new command, then phase expiry.
    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        turn_done_d  = 1'b0;
        timer_load   = 1'b0;
        timer_enable = 1'b0;
        timer_value  = SETTLE_LOAD;

        if (!random_enable) begin
            state_d = ST_IDLE;
        end else if (cmd_load) begin
            cmd_d      = cmd;
            timer_load = 1'b1;
            if (new_angle != 8'd0) begin
                state_d     = ST_TURN;
                timer_value = turn_load;
            end else begin
                state_d     = ST_SETTLE;
            end
        end else begin
            unique case (state_q)
                ST_TURN: begin
                    if (timer_expired) begin
                        state_d     = ST_SETTLE;
                        turn_done_d = 1'b1;
                        timer_load  = 1'b1;
                    end else begin
                        timer_enable = 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (timer_expired) begin
                        state_d = ST_DRIVE;
                    end else begin
                        timer_enable = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        wheels_d = WHEELS_STOP;
        unique case (state_d)
            ST_TURN:  wheels_d = turn_wheels(cmd_d[CMD_CW], cmd_d[CMD_SPIN], TURN_SPEED);
            ST_DRIVE: wheels_d = '{left_speed: DRIVE_SPEED, right_speed: DRIVE_SPEED,
                                   left_dir: DIR_FWD, right_dir: DIR_FWD};
            default:  ;
        endcase
        busy_d = (state_d == ST_TURN) || (state_d == ST_SETTLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cmd_q       <= '0;
            wheels_q    <= WHEELS_STOP;
            busy_q      <= 1'b0;
            turn_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            wheels_q    <= wheels_d;
            busy_q      <= busy_d;
            turn_done_q <= turn_done_d;
        end
    end

    assign left_speed  = wheels_q.left_speed;
    assign right_speed = wheels_q.right_speed;
    assign left_dir    = wheels_q.left_dir;
    assign right_dir   = wheels_q.right_dir;
    assign busy        = busy_q;
    assign turn_done   = turn_done_q;

endmodule

// File: tb/tb_random_move_executor.sv
// Directed scoreboard bench for random_move_executor: every stimulus cycle queues the
// hand-derived wheel/busy/turn_done word expected after the following rising edge.
module tb_random_move_executor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       random_enable = 1'b0;
    logic       cmd_load = 1'b0;
    logic [9:0] cmd = '0;
    logic [7:0] left_speed;
    logic [7:0] right_speed;
    logic       left_dir;
    logic       right_dir;
    logic       busy;
    logic       turn_done;

    random_move_executor dut (
        .clk           (clk),
        .rst           (rst),
        .random_enable (random_enable),
        .cmd_load      (cmd_load),
        .cmd           (cmd),
        .left_speed    (left_speed),
        .right_speed   (right_speed),
        .left_dir      (left_dir),
        .right_dir     (right_dir),
        .busy          (busy),
        .turn_done     (turn_done)
    );

    always #5 clk = ~clk;

    // {left_speed, right_speed, left_dir, right_dir, busy, turn_done}
    localparam logic [19:0] IDLE_V        = {8'd0,   8'd0,   1'b1, 1'b1, 1'b0, 1'b0};
    localparam logic [19:0] SETTLE_V      = {8'd0,   8'd0,   1'b1, 1'b1, 1'b1, 1'b0};
    localparam logic [19:0] SETTLE_DONE_V = {8'd0,   8'd0,   1'b1, 1'b1, 1'b1, 1'b1};
    localparam logic [19:0] DRIVE_V       = {8'd128, 8'd128, 1'b1, 1'b1, 1'b0, 1'b0};
    localparam logic [19:0] SPIN_CCW_V    = {8'd64,  8'd64,  1'b0, 1'b1, 1'b1, 1'b0};
    localparam logic [19:0] SPIN_CW_V     = {8'd64,  8'd64,  1'b1, 1'b0, 1'b1, 1'b0};
    localparam logic [19:0] PIVOT_CW_V    = {8'd64,  8'd0,   1'b1, 1'b1, 1'b1, 1'b0};
    localparam logic [19:0] PIVOT_CCW_V   = {8'd0,   8'd64,  1'b1, 1'b1, 1'b1, 1'b0};

    typedef struct {
        logic [19:0] v;
        string       tag;
    } exp_t;

    exp_t scoreboard[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic checkOutput(input logic [19:0] e, input string tag);
        logic [19:0] actual;
        actual = {left_speed, right_speed, left_dir, right_dir, busy, turn_done};
        vectors++;
        if (actual !== e) begin
            miscompares++;
            $display("[TB] FAIL %s @%0t: got ls=%0d rs=%0d ld=%b rd=%b busy=%b done=%b, expected ls=%0d rs=%0d ld=%b rd=%b busy=%b done=%b",
                     tag, $time, actual[19:12], actual[11:4], actual[3], actual[2], actual[1], actual[0],
                     e[19:12], e[11:4], e[3], e[2], e[1], e[0]);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic load, input logic [9:0] c,
                                 input logic [19:0] e, input string tag);
        exp_t item;
        @(negedge clk);
        random_enable = en;
        cmd_load      = load;
        cmd           = c;
        item.v   = e;
        item.tag = tag;
        scoreboard.push_back(item);
    endtask

    task automatic applyRun(input logic en, input logic [9:0] c, input logic [19:0] e,
                            input int n, input string tag);
        for (int i = 0; i < n; i++) applyStimulus(en, 1'b0, c, e, tag);
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 8 && scoreboard.size() > 0; i++) begin
            @(posedge clk);
            #2;
        end
        if (scoreboard.size() > 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL drain: got %0d pending expectations, expected 0", scoreboard.size());
        end
    endtask

    // Monitor: one expectation consumed per rising edge, sampled just after the edge.
    initial begin
        exp_t item;
        forever begin
            @(posedge clk);
            #1;
            if (scoreboard.size() > 0) begin
                item = scoreboard.pop_front();
                checkOutput(item.v, item.tag);
            end
        end
    end

    initial begin
        #2 rst = 1'b0;
        #1 checkOutput(IDLE_V, "reset_state");
        @(negedge clk);
        rst = 1'b1;

        // Spin CCW, angle 3: 48 turn cycles, done pulse, 4 settle, drive.
        applyStimulus(1'b1, 1'b1, 10'b01_00000011, SPIN_CCW_V, "spin_ccw_first");
        applyRun(1'b1, 10'b01_00000011, SPIN_CCW_V, 47, "spin_ccw_turn");
        applyRun(1'b1, 10'b01_00000011, SETTLE_DONE_V, 1, "spin_ccw_done");
        applyRun(1'b1, 10'b01_00000011, SETTLE_V, 3, "spin_ccw_settle");
        applyRun(1'b1, 10'b01_00000011, DRIVE_V, 3, "spin_ccw_drive");

        // Angle zero from DRIVE: straight to settle, no done pulse.
        applyStimulus(1'b1, 1'b1, 10'b11_00000000, SETTLE_V, "zero_first_settle");
        applyRun(1'b1, 10'b11_00000000, SETTLE_V, 3, "zero_settle");
        applyRun(1'b1, 10'b11_00000000, DRIVE_V, 2, "zero_drive");

        // Enable drop beats a simultaneous load.
        applyStimulus(1'b0, 1'b1, 10'b01_00000011, IDLE_V, "drop_beats_load");
        applyRun(1'b0, 10'b01_00000011, IDLE_V, 2, "drop_idle");

        // Pivot CW aborted after 10 turn cycles.
        applyStimulus(1'b1, 1'b1, 10'b10_00001010, PIVOT_CW_V, "pivot_cw_first");
        applyRun(1'b1, 10'b10_00001010, PIVOT_CW_V, 9, "pivot_cw_turn");
        applyStimulus(1'b0, 1'b0, 10'b10_00001010, IDLE_V, "abort_idle");
        applyRun(1'b0, 10'b10_00001010, IDLE_V, 3, "abort_no_done");

        // Load on the final turn cycle restarts the turn without a done pulse.
        applyStimulus(1'b1, 1'b1, 10'b01_00000001, SPIN_CCW_V, "short_spin_first");
        applyRun(1'b1, 10'b01_00000001, SPIN_CCW_V, 15, "short_spin_turn");
        applyStimulus(1'b1, 1'b1, 10'b11_00000010, SPIN_CW_V, "reload_last_cycle");
        applyRun(1'b1, 10'b11_00000010, SPIN_CW_V, 31, "spin_cw_turn");
        applyRun(1'b1, 10'b11_00000010, SETTLE_DONE_V, 1, "spin_cw_done");
        applyRun(1'b1, 10'b11_00000010, SETTLE_V, 3, "spin_cw_settle");
        applyRun(1'b1, 10'b11_00000010, DRIVE_V, 2, "spin_cw_drive");

        // Retrigger from DRIVE with pivot CCW, angle 1.
        applyStimulus(1'b1, 1'b1, 10'b00_00000001, PIVOT_CCW_V, "retrig_first");
        applyRun(1'b1, 10'b00_00000001, PIVOT_CCW_V, 15, "retrig_turn");
        applyRun(1'b1, 10'b00_00000001, SETTLE_DONE_V, 1, "retrig_done");
        applyRun(1'b1, 10'b00_00000001, SETTLE_V, 3, "retrig_settle");
        applyRun(1'b1, 10'b00_00000001, DRIVE_V, 2, "retrig_drive");

        // Asynchronous reset mid-drive, then loads ignored while random mode is off.
        waitDrain();
        @(posedge clk);
        #3 rst = 1'b0;
        #1 checkOutput(IDLE_V, "reset_async");
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b1, 10'b01_00000011, IDLE_V, "ignore_load");
        applyRun(1'b0, 10'b01_00000011, IDLE_V, 3, "ignore_idle");
        applyRun(1'b1, 10'b01_00000011, IDLE_V, 2, "enable_no_load");

        waitDrain();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/random_move_executor.md
Name: random_move_executor

Overview:
- Consumer end of the motion-decision turn-command interface.
- Takes the 10-bit random turn command (bit9 = turn clockwise, bit8 = spin, bits[7:0] = angle units) plus the random-mode enable, and converts it into timed wheel commands.
- Sequence: turn for a duration proportional to angle, short motor settle, then straight forward drive until released.
- Sits between the motion decision FSM and the move-type mux's RAND input.

Parameters:
- TICKS_PER_DEG, 16, clock cycles of turning per angle unit.
- SETTLE_CYCLES, 4, zero-speed cycles between turn and drive.
- TURN_SPEED, 8'd64, wheel magnitude while turning.
- DRIVE_SPEED, 8'd128, wheel magnitude while driving straight.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- random_enable  in  1  level; high = random mode owns the wheels.
- cmd_load  in  1  single-cycle strobe; latch cmd.
- cmd  in  10  [9] clockwise, [8] spin (1 = spin in place, 0 = pivot), [7:0] angle.
- left_speed  out  8  left wheel magnitude.
- right_speed  out  8  right wheel magnitude.
- left_dir  out  1  1 = forward, 0 = reverse.
- right_dir  out  1  1 = forward, 0 = reverse.
- busy  out  1  high in TURN or SETTLE.
- turn_done  out  1  one-cycle pulse when the turn completes.

Behaviour:
- Reset (rst = 0, asynchronous):
  - state IDLE, speeds 0, dirs 1, busy 0, turn_done 0.
  - Latched cmd cleared, counter cleared.
- All outputs are registered and update on the same edge as the state.
- States: IDLE, TURN, SETTLE, DRIVE.
- IDLE: speeds 0, dirs 1.
  - cmd_load = 1 and random_enable = 1 at edge N: latch cmd.
  - Angle != 0: enter TURN at N+1 with count = angle*TICKS_PER_DEG.
  - Angle == 0: enter SETTLE directly. No TURN cycle and no turn_done.
- TURN outputs:
  - Spin CW: left fwd TURN_SPEED, right rev TURN_SPEED.
  - Spin CCW: left rev, right fwd.
  - Pivot CW: left fwd TURN_SPEED, right 0 fwd.
  - Pivot CCW: left 0 fwd, right fwd TURN_SPEED.
- TURN timing:
  - TURN outputs are present for exactly angle*TICKS_PER_DEG cycles.
  - On the last TURN cycle's edge, move to SETTLE with turn_done = 1 for that first SETTLE cycle.
- SETTLE: speeds 0, dirs 1 for exactly SETTLE_CYCLES cycles, then DRIVE.
- DRIVE: both fwd DRIVE_SPEED, held indefinitely.
- Counter: 24-bit down-counter. Product of max angle 255 and TICKS_PER_DEG must fit; elaboration check enforces ≤ 2^24-1.
- random_enable low in any state: next edge goes to IDLE with zero outputs. No turn_done. Latched cmd is retained but unused.
- cmd_load with random_enable = 1 in TURN, SETTLE or DRIVE: relatch and restart from the TURN or SETTLE entry rule above. Any pending turn_done is suppressed.
- Priorities on the same edge: random_enable low > cmd_load > counter expiry.
- cmd_load while random_enable low is ignored.
- busy = 1 exactly in TURN and SETTLE.
- Reset mid-operation: asynchronous return to reset values. No pulse on release.

Decomposition:
- Shared package (motion_pkg):
  - state encoding.
  - command bit positions: CMD_CW = 9, CMD_SPIN = 8, CMD_ANGLE[7:0].
  - DIR_FWD/DIR_REV constants.
  - default speeds.
- One sub-module: turn_timer, a loadable 24-bit down-counter with load, enable, and expired output. Reused for both the TURN and SETTLE durations.

Test Plan:
- Spin CCW: random_enable = 1, cmd = 10'b01_00000011, cmd_load pulse → 48 cycles of left rev 64 / right fwd 64, busy = 1; turn_done pulse on cycle 49; 4 cycles of zeros; then left = right = fwd 128 with busy = 0.
- Angle zero: cmd = 10'b11_00000000 → no TURN cycles, no turn_done; 4 SETTLE cycles, then DRIVE fwd 128.
- Abort: cmd = 10'b10_00001010 (pivot CW, 160 cycles); drop random_enable after 10 TURN cycles → next cycle all zeros, IDLE, busy = 0; turn_done never asserts.
- Retrigger: in DRIVE, cmd_load with cmd = 10'b00_00000001 → next cycle pivot CCW (left 0, right fwd 64) for 16 cycles, turn_done, settle, drive.
- Reset and ignore: assert rst mid-DRIVE → outputs zero before the next clock edge. After release, cmd_load with random_enable = 0 → outputs stay zero, busy = 0.
- Simultaneous events: cmd_load on the same edge that random_enable falls → IDLE wins. cmd_load on the final TURN cycle → turn restarts with the new cmd and no turn_done.
